// File: rtl/sseg_scan_decoder.sv
// Seven-segment scan decoder: samples multiplexed anode/segment lines,
// decodes stable patterns to nibbles and assembles complete 4-digit frames.
module sseg_scan_decoder #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] live,
  output logic [3:0]  seen,
  output logic [15:0] frame,
  output logic        frame_valid,
  output logic [7:0]  frame_count,
  output logic        err_seg,
  output logic        err_an
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CPRE = CW'(SETTLE_CYCLES - 1);

  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic [CW-1:0] cnt;

  logic        same;
  logic        capture;
  logic        blank;
  logic        an_ok;
  logic [1:0]  idx;
  logic [3:0]  onehot;
  logic [4:0]  dec;
  logic [15:0] live_n;
  logic [3:0]  seen_n;

  // {ok, nibble}; segments are active-low GFEDCBA
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    same    = ({an, seg} == {r_an, r_seg});
    capture = same && (cnt == CPRE);
    blank   = (r_an == 4'b1111);
    an_ok   = 1'b1;
    idx     = 2'd0;
    onehot  = 4'b0000;
    case (r_an)
      4'b1110: begin idx = 2'd0; onehot = 4'b0001; end
      4'b1101: begin idx = 2'd1; onehot = 4'b0010; end
      4'b1011: begin idx = 2'd2; onehot = 4'b0100; end
      4'b0111: begin idx = 2'd3; onehot = 4'b1000; end
      default: an_ok = 1'b0;
    endcase
    dec    = decode(r_seg);
    live_n = live;
    live_n[{idx, 2'b00} +: 4] = dec[3:0];
    // a repeated digit means a slot was missed: restart the frame
    seen_n = ((seen & onehot) != 4'b0000) ? onehot : (seen | onehot);
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      r_an        <= 4'b0000;
      r_seg       <= 7'b0000000;
      cnt         <= '0;
      live        <= 16'h0000;
      seen        <= 4'b0000;
      frame       <= 16'h0000;
      frame_valid <= 1'b0;
      frame_count <= 8'h00;
      err_seg     <= 1'b0;
      err_an      <= 1'b0;
    end else begin
      r_an        <= an;
      r_seg       <= seg;
      frame_valid <= 1'b0;
      if (!same)
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + 1'b1;
      if (capture && !blank) begin
        if (!an_ok) begin
          err_an <= 1'b1;
        end else if (!dec[4]) begin
          err_seg <= 1'b1;
        end else begin
          live <= live_n;
          if (seen_n == 4'b1111) begin
            frame       <= live_n;
            frame_valid <= 1'b1;
            frame_count <= frame_count + 8'd1;
            seen        <= 4'b0000;
          end else begin
            seen <= seen_n;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboard bench for sseg_scan_decoder: expected frames are queued
// by the stimulus and checked by a monitor on every frame_valid pulse.
module tb_sseg_scan_decoder;

  logic        clk = 1'b0;
  logic        btnC;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] live;
  logic [3:0]  seen;
  logic [15:0] frame;
  logic        frame_valid;
  logic [7:0]  frame_count;
  logic        err_seg;
  logic        err_an;

  sseg_scan_decoder dut (
    .clk(clk),
    .btnC(btnC),
    .an(an),
    .seg(seg),
    .live(live),
    .seen(seen),
    .frame(frame),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .err_seg(err_seg),
    .err_an(err_an)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  exp_count;

  logic [6:0] pat [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [3:0] anode [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  // called and returns on a falling edge
  task automatic put(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic dig(input int i, input logic [3:0] v);
    put(anode[i], pat[v], 2);
  endtask

  task automatic expect_frame(input logic [15:0] f);
    exp_count = exp_count + 8'd1;
    exp_q.push_back({exp_count, f});
  endtask

  task automatic do_reset();
    btnC = 1'b1;
    an   = 4'b1111;
    seg  = 7'h7F;
    @(posedge clk);
    @(negedge clk);
    btnC = 1'b0;
    exp_count = 8'h00;
  endtask

  // monitor: every frame_valid pulse must match the head of the queue
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_valid", {8'h0, frame}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("frame", {16'h0, frame}, {16'h0, e[15:0]});
          chk("frame_count", {24'h0, frame_count}, {24'h0, e[23:16]});
          chk("seen_after_frame", {28'h0, seen}, 32'h0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a4, b4;
    btnC = 1'b1;
    an   = 4'b1111;
    seg  = 7'h7F;
    exp_count = 8'h00;
    @(negedge clk);
    do_reset();

    chk("rst_live", {16'h0, live}, 32'h0);
    chk("rst_seen", {28'h0, seen}, 32'h0);
    chk("rst_frame", {16'h0, frame}, 32'h0);
    chk("rst_fv", {31'h0, frame_valid}, 32'h0);
    chk("rst_count", {24'h0, frame_count}, 32'h0);
    chk("rst_errs", {30'h0, err_seg, err_an}, 32'h0);

    // basic scan: 5, 2, E, 7
    put(4'b1110, 7'b0010010, 2);
    put(4'b1101, 7'b0100100, 2);
    put(4'b1011, 7'b0000110, 2);
    expect_frame(16'h7E25);
    put(4'b0111, 7'b1111000, 2);
    @(negedge clk);
    chk("basic_live", {16'h0, live}, 32'h7E25);
    chk("basic_count", {24'h0, frame_count}, 32'h1);
    chk("basic_seen", {28'h0, seen}, 32'h0);
    chk("basic_fv_low", {31'h0, frame_valid}, 32'h0);
    chk("basic_errs", {30'h0, err_seg, err_an}, 32'h0);

    // sweep all {B,A}
    do_reset();
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 16; a++) begin
        a4 = 4'(a);
        b4 = 4'(b);
        dig(0, a4);
        dig(1, b4);
        dig(2, a4 + b4);
        expect_frame({a4 - b4, a4 + b4, b4, a4});
        dig(3, a4 - b4);
      end
    end
    @(negedge clk);
    chk("sweep_count_wrap", {24'h0, frame_count}, 32'h0);
    chk("sweep_live", {16'h0, live}, 32'h0EFF);

    // undecodable segments
    put(4'b1110, 7'b1000001, 2);
    chk("errseg_flag", {31'h0, err_seg}, 32'h1);
    chk("errseg_seen", {28'h0, seen}, 32'h0);
    chk("errseg_live", {16'h0, live}, 32'h0EFF);
    chk("errseg_no_an", {31'h0, err_an}, 32'h0);
    dig(0, 4'h1);
    dig(1, 4'h2);
    dig(2, 4'h3);
    expect_frame(16'h4321);
    dig(3, 4'h4);
    chk("errseg_sticky", {31'h0, err_seg}, 32'h1);

    // short glitch, illegal anode, blank
    dig(0, 4'h3);
    put(4'b1101, pat[8], 1);
    dig(2, 4'h4);
    chk("glitch_seen", {28'h0, seen}, 32'h5);
    chk("glitch_live", {16'h0, live}, 32'h4423);
    chk("glitch_no_an", {31'h0, err_an}, 32'h0);
    put(4'b1100, pat[1], 2);
    chk("erran_flag", {31'h0, err_an}, 32'h1);
    chk("erran_seen", {28'h0, seen}, 32'h5);
    put(4'b1111, pat[0], 3);
    chk("blank_seen", {28'h0, seen}, 32'h5);
    chk("blank_live", {16'h0, live}, 32'h4423);
    dig(1, 4'h9);
    expect_frame(16'hB493);
    dig(3, 4'hB);

    // duplicate digit restarts frame
    dig(0, 4'h1);
    dig(1, 4'h2);
    dig(0, 4'h3);
    chk("dup_seen", {28'h0, seen}, 32'h1);
    dig(1, 4'h4);
    dig(2, 4'h5);
    expect_frame(16'h6543);
    dig(3, 4'h6);

    // reset mid-frame
    dig(0, 4'hA);
    dig(1, 4'hB);
    dig(2, 4'hC);
    do_reset();
    chk("midrst_live", {16'h0, live}, 32'h0);
    chk("midrst_seen", {28'h0, seen}, 32'h0);
    chk("midrst_frame", {16'h0, frame}, 32'h0);
    chk("midrst_count", {24'h0, frame_count}, 32'h0);
    chk("midrst_errs", {30'h0, err_seg, err_an}, 32'h0);
    dig(3, 4'hD);
    dig(2, 4'hC);
    dig(1, 4'hB);
    expect_frame(16'hDCBA);
    dig(0, 4'hA);
    @(negedge clk);
    chk("post_rst_count", {24'h0, frame_count}, 32'h1);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
